// File: rtl/sram_controller.sv
// sram_controller: password-gated host-to-async-SRAM bridge with registered
// strobes, auto-incrementing bursts and protocol-error flagging.
// Latency: 1 cycle from request edge to SRAM strobes; read data is combinational.
// Backpressure: none; the host holds we_n/oe_n low for as many cycles as it wants beats.
// Ports: clk/rst_n; host side addr, data(inout), we_n, oe_n, password, burst_mode,
//   burst_length; SRAM side cs_n, sram_addr, sram_data(inout), sram_we_n, sram_oe_n;
//   status error_flag, access_denied, power_save_mode.
// Optional feature macro: POWER_SAVE_EN (idle counter + power_save_mode).
module sram_controller #(
  parameter logic [7:0]  PASSWORD    = 8'hA5,
  parameter int unsigned IDLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  inout  wire  [7:0]  data,
  input  logic        we_n,
  input  logic        oe_n,
  input  logic [7:0]  password,
  input  logic        burst_mode,
  input  logic [15:0] burst_length,
  output logic        cs_n,
  output logic [15:0] sram_addr,
  inout  wire  [7:0]  sram_data,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic        error_flag,
  output logic        access_denied,
  output logic        power_save_mode
);

  // READY: single accesses / burst start; BURST: auto-increment beats;
  // HOLD: burst exhausted, strobes parked until the host releases the request.
  typedef enum logic [1:0] {ST_READY, ST_BURST, ST_HOLD} state_t;

  state_t      state_q;
  logic        cs_n_q;
  logic        sram_we_n_q;
  logic        sram_oe_n_q;
  logic [15:0] sram_addr_q;
  logic [7:0]  wdata_q;
  logic        error_q;
  logic        denied_q;
  logic [15:0] burst_cnt_q;   // beats still to issue after the current one
  logic        burst_wr_q;    // burst direction, fixed at burst start

  logic        req_d;
  logic        auth_d;
  logic        both_low_d;
  logic [15:0] burst_len_d;
  logic [15:0] addr_inc_d;
  logic        wrap_d;

  assign req_d       = !we_n || !oe_n;
  assign auth_d      = (password == PASSWORD);
  assign both_low_d  = !we_n && !oe_n;
  // A zero-length burst still performs one beat.
  assign burst_len_d = (burst_length == 16'd0) ? 16'd1 : burst_length;
  assign addr_inc_d  = sram_addr_q + 16'd1;
  assign wrap_d      = (sram_addr_q == 16'hFFFF);

`ifdef POWER_SAVE_EN
  localparam logic [15:0] IDLE_MAX = 16'(IDLE_CYCLES);
  logic [15:0] idle_cnt_q;
  logic        ps_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_READY;
      cs_n_q      <= 1'b1;
      sram_we_n_q <= 1'b1;
      sram_oe_n_q <= 1'b1;
      sram_addr_q <= 16'h0000;
      wdata_q     <= 8'h00;
      error_q     <= 1'b0;
      denied_q    <= 1'b0;
      burst_cnt_q <= 16'd0;
      burst_wr_q  <= 1'b0;
`ifdef POWER_SAVE_EN
      idle_cnt_q  <= 16'd0;
      ps_q        <= 1'b0;
`endif
    end else begin
      error_q <= 1'b0;
      if (!req_d) begin
        // Release ends any access or burst in progress.
        cs_n_q      <= 1'b1;
        sram_we_n_q <= 1'b1;
        sram_oe_n_q <= 1'b1;
        state_q     <= ST_READY;
      end else if (!auth_d) begin
        // Deny outranks any protocol error on the same edge.
        cs_n_q      <= 1'b1;
        sram_we_n_q <= 1'b1;
        sram_oe_n_q <= 1'b1;
        denied_q    <= 1'b1;
        state_q     <= ST_READY;
      end else begin
        denied_q <= 1'b0;
        error_q  <= both_low_d;
        case (state_q)
          ST_READY: begin
            cs_n_q      <= 1'b0;
            sram_addr_q <= addr;
            // Write wins when both requests are low.
            sram_we_n_q <= we_n;
            sram_oe_n_q <= !we_n;
            if (!we_n) wdata_q <= data;
            if (burst_mode) begin
              burst_cnt_q <= burst_len_d - 16'd1;
              burst_wr_q  <= !we_n;
              state_q     <= ST_BURST;
            end
          end
          ST_BURST: begin
            if (burst_cnt_q != 16'd0) begin
              cs_n_q      <= 1'b0;
              sram_addr_q <= addr_inc_d;
              sram_we_n_q <= !burst_wr_q;
              sram_oe_n_q <= burst_wr_q;
              if (burst_wr_q) wdata_q <= data;
              burst_cnt_q <= burst_cnt_q - 16'd1;
              if (wrap_d) error_q <= 1'b1;
            end else begin
              cs_n_q      <= 1'b1;
              sram_we_n_q <= 1'b1;
              sram_oe_n_q <= 1'b1;
              state_q     <= ST_HOLD;
            end
          end
          default: begin
            cs_n_q      <= 1'b1;
            sram_we_n_q <= 1'b1;
            sram_oe_n_q <= 1'b1;
          end
        endcase
      end
`ifdef POWER_SAVE_EN
      // Any request, granted or not, wakes the controller on the same edge.
      // cs_n is already parked high on every idle edge, so power-save needs
      // no separate chip-select override.
      if (req_d) begin
        idle_cnt_q <= 16'd0;
        ps_q       <= 1'b0;
      end else begin
        if (idle_cnt_q != IDLE_MAX) idle_cnt_q <= idle_cnt_q + 16'd1;
        if (idle_cnt_q >= IDLE_MAX - 16'd1) ps_q <= 1'b1;
      end
`endif
    end
  end

  assign cs_n          = cs_n_q;
  assign sram_addr     = sram_addr_q;
  assign sram_we_n     = sram_we_n_q;
  assign sram_oe_n     = sram_oe_n_q;
  assign error_flag    = error_q;
  assign access_denied = denied_q;
`ifdef POWER_SAVE_EN
  assign power_save_mode = ps_q;
`else
  assign power_save_mode = 1'b0;
`endif

  // Tri-state buses: SRAM side driven only during a write strobe, host side
  // only while an SRAM read is enabled.
  assign sram_data = !sram_we_n_q ? wdata_q : 8'hzz;
  assign data      = (!cs_n_q && !sram_oe_n_q) ? sram_data : 8'hzz;

endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] addr;
  logic        we_n, oe_n;
  logic [7:0]  password;
  logic        burst_mode;
  logic [15:0] burst_length;
  logic        host_drv;
  logic [7:0]  host_dat;
  wire  [7:0]  data_w;
  wire  [7:0]  sram_dq;
  logic        cs_n, sram_we_n, sram_oe_n, error_flag, access_denied, power_save_mode;
  logic [15:0] sram_addr;

`ifdef POWER_SAVE_EN
  localparam bit PS_EXP = 1'b1;
`else
  localparam bit PS_EXP = 1'b0;
`endif

  sram_controller #(.PASSWORD(8'hA5), .IDLE_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .data(data_w), .we_n(we_n), .oe_n(oe_n),
    .password(password), .burst_mode(burst_mode), .burst_length(burst_length),
    .cs_n(cs_n), .sram_addr(sram_addr), .sram_data(sram_dq), .sram_we_n(sram_we_n),
    .sram_oe_n(sram_oe_n), .error_flag(error_flag), .access_denied(access_denied),
    .power_save_mode(power_save_mode)
  );

  assign data_w = host_drv ? host_dat : 8'hzz;

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Asynchronous SRAM device model: content preset from init_val, written
  // mid-cycle while the write strobe is low.
  logic [7:0] sram_mem [0:65535];
  assign sram_dq = (!cs_n && !sram_oe_n) ? sram_mem[sram_addr] : 8'hzz;
  initial begin
    for (int i = 0; i < 65536; i++) sram_mem[i] = init_val(16'(i));
    forever begin
      @(negedge clk);
      if (!cs_n && !sram_we_n) sram_mem[sram_addr] = sram_dq;
    end
  end

  // Reference model: expected SRAM contents plus an expected-beat queue.
  typedef struct {
    logic [15:0] a;
    bit          wr;
    logic [7:0]  d;
    bit          err;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] ref_mem [int];
  int         checks = 0;
  int         failures = 0;

  function automatic logic [7:0] ref_read(input logic [15:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle with chip select low must match the next expected beat.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && cs_n === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_access actual_addr=%0h expected=no_access t=%0t", sram_addr, $time);
        end else begin
          b = exp_q.pop_front();
          check("sram_addr", sram_addr, b.a);
          check("sram_we_n", sram_we_n, !b.wr);
          check("sram_oe_n", sram_oe_n, b.wr);
          if (b.wr) check("wr_data", sram_dq, b.d);
          else      check("rd_data", data_w, b.d);
          check("error_flag", error_flag, b.err);
        end
      end else if (rst_n === 1'b1) begin
        check("error_flag_idle", error_flag, 0);
      end
    end
  end

  task automatic idle_inputs();
    we_n = 1'b1; oe_n = 1'b1; host_drv = 1'b0; burst_mode = 1'b0;
  endtask

  // Holds one request for 'hold' edges, then releases it for one edge.
  task automatic run_txn(input bit wr, input bit burst, input logic [15:0] len, input int hold,
                         input logic [15:0] a, input logic [7:0] pw, input bit both_low,
                         input logic [31:0] dpat);
    bit          auth;
    int          neff, nbeats;
    logic [15:0] ca, baddr;
    logic [7:0]  d;
    beat_t       b;
    auth   = (pw == 8'hA5);
    neff   = (len == 16'd0) ? 1 : int'(len);
    nbeats = !auth ? 0 : (burst ? ((hold < neff) ? hold : neff) : hold);
    for (int c = 0; c < hold; c++) begin
      ca = (c == 0) ? a : 16'($urandom);
      d  = (c < 4) ? dpat[c*8 +: 8] : 8'($urandom);
      addr         = ca;
      we_n         = !wr;
      oe_n         = wr ? !both_low : 1'b0;
      password     = pw;
      burst_mode   = (c == 0 || !burst) ? burst : 1'($urandom);
      burst_length = (c == 0) ? len : 16'($urandom);
      host_drv     = wr;
      host_dat     = d;
      if (c < nbeats) begin
        baddr = burst ? a + 16'(c) : ca;
        b.a   = baddr;
        b.wr  = wr;
        b.err = both_low || (burst && c > 0 && baddr == 16'h0000);
        if (wr) begin
          b.d = d;
          ref_mem[int'(baddr)] = d;
        end else begin
          b.d = ref_read(baddr);
        end
        exp_q.push_back(b);
      end
      @(posedge clk); #1;
      if (c == 0) check("ps_cleared_by_req", power_save_mode, 0);
    end
    idle_inputs();
    @(posedge clk); #1;
    check("access_denied", access_denied, !auth);
  endtask

  initial begin
    rst_n = 1'b0;
    addr = 16'h0; password = 8'h00; burst_length = 16'd0; host_dat = 8'h00;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_cs_n", cs_n, 1);
    check("rst_we_n", sram_we_n, 1);
    check("rst_oe_n", sram_oe_n, 1);
    check("rst_addr", sram_addr, 0);
    check("rst_err", error_flag, 0);
    check("rst_denied", access_denied, 0);
    check("rst_ps", power_save_mode, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single writes and read-back.
    run_txn(1, 0, 0, 1, 16'h0001, 8'hA5, 0, 32'h000000AA);
    run_txn(1, 0, 0, 1, 16'h0002, 8'hA5, 0, 32'h000000BB);
    run_txn(0, 0, 0, 1, 16'h0001, 8'hA5, 0, 32'h0);
    run_txn(0, 0, 0, 1, 16'h0002, 8'hA5, 0, 32'h0);
    check("mem_0001", sram_mem[16'h0001], 8'hAA);
    check("mem_0002", sram_mem[16'h0002], 8'hBB);

    // Bursts: held past N to confirm the burst stops, then read back, then wrap.
    run_txn(1, 1, 16'd4, 6, 16'h0100, 8'hA5, 0, 32'hFFEEDDCC);
    run_txn(0, 1, 16'd4, 4, 16'h0100, 8'hA5, 0, 32'h0);
    check("mem_0103", sram_mem[16'h0103], 8'hFF);
    run_txn(1, 1, 16'd2, 2, 16'hFFFF, 8'hA5, 0, 32'h00001234);
    run_txn(0, 1, 16'd0, 3, 16'h0050, 8'hA5, 0, 32'h0);

    // Denied write, then authorised write clears the sticky flag.
    run_txn(1, 0, 0, 1, 16'h0004, 8'hFF, 0, 32'h00000022);
    check("mem_0004_untouched", sram_mem[16'h0004], init_val(16'h0004));
    run_txn(1, 0, 0, 1, 16'h0004, 8'hA5, 0, 32'h00000033);

    // Both strobes low: write proceeds with a single-cycle error pulse.
    run_txn(1, 0, 0, 1, 16'h0006, 8'hA5, 1, 32'h00000077);
    // Denied with both low: no error.
    run_txn(1, 0, 0, 1, 16'h0007, 8'h00, 1, 32'h00000078);

    // Power-save entry after exactly 16 idle edges (release edge counted).
    repeat (14) @(posedge clk);
    #1;
    check("ps_after_15_idle", power_save_mode, 0);
    @(posedge clk); #1;
    check("ps_after_16_idle", power_save_mode, PS_EXP);
    check("ps_cs_n", cs_n, 1);
    run_txn(0, 0, 0, 1, 16'h0005, 8'hA5, 0, 32'h0);

    // Reset during beat 2 of a 4-beat burst.
    begin
      beat_t b;
      logic [7:0] d;
      for (int c = 0; c < 3; c++) begin
        d            = 8'h90 + 8'(c);
        addr         = (c == 0) ? 16'h0400 : 16'($urandom);
        we_n         = 1'b0; oe_n = 1'b1; password = 8'hA5;
        burst_mode   = 1'b1; burst_length = 16'd4;
        host_drv     = 1'b1; host_dat = d;
        b.a = 16'h0400 + 16'(c); b.wr = 1'b1; b.d = d; b.err = 1'b0;
        ref_mem[int'(b.a)] = d;
        exp_q.push_back(b);
        @(posedge clk); #1;
      end
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("midrst_cs_n", cs_n, 1);
      check("midrst_we_n", sram_we_n, 1);
      check("midrst_oe_n", sram_oe_n, 1);
      check("midrst_addr", sram_addr, 0);
      check("midrst_err", error_flag, 0);
      check("midrst_ps", power_save_mode, 0);
      idle_inputs();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("midrst_no_beat", cs_n, 1);
    end
    run_txn(1, 0, 0, 1, 16'h0200, 8'hA5, 0, 32'h00000044);
    run_txn(0, 0, 0, 1, 16'h0200, 8'hA5, 0, 32'h0);

    // Randomised mix against the reference model.
    for (int t = 0; t < 150; t++) begin
      bit          wr, burst, bl;
      logic [15:0] len, a;
      logic [7:0]  pw;
      int          hold;
      wr    = 1'($urandom);
      burst = ($urandom_range(0, 2) == 0);
      len   = 16'($urandom_range(0, 6));
      hold  = $urandom_range(1, 7);
      case ($urandom_range(0, 3))
        0:       a = 16'hFFFF - 16'($urandom_range(0, 3));
        1, 2:    a = 16'h0300 + 16'($urandom_range(0, 31));
        default: a = 16'($urandom);
      endcase
      pw = 8'hA5;
      if ($urandom_range(0, 5) == 0) begin
        pw = 8'($urandom);
        if (pw == 8'hA5) pw = 8'h5A;
      end
      bl = !burst && wr && ($urandom_range(0, 3) == 0);
      run_txn(wr, burst, len, hold, a, pw, bl, $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (2) @(posedge clk);
    #1;
    check("beats_all_seen", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
